maze_tile_renderer: RTL and testbench

Pixel-source stage that sits directly upstream of the VGA output pins. It consumes the pixel coordinates, sync and display-enable produced by the VGA timing generator and returns a coloured pixel. Colour comes from an 8x8-tile maze map (written by game logic), a 2-bit-per-pixel tile pattern ROM and a 4-entry palette. Sync signals are re-aligned to the pipeline latency, so the outputs drive the VGA pins directly.

---
 rtl/maze_pkg.sv | 35 +++
 rtl/tile_map_ram.sv | 22 ++
 rtl/maze_tile_renderer.sv | 82 ++++++++
 tb/tb_maze_tile_renderer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared constants, tile-index enum and pattern ROM contents for the maze renderer.
package maze_pkg;
  localparam int TILE_PX = 8;
  localparam int MAP_COLS = 80;
  localparam int MAP_ROWS = 60;
  localparam int MAP_DEPTH = MAP_COLS * MAP_ROWS;
  localparam int MAP_AW = 13;
  localparam logic [7:0] PAL0_RST = 8'h00;
  localparam logic [7:0] PAL1_RST = 8'h03;
  localparam logic [7:0] PAL2_RST = 8'hFC;
  localparam logic [7:0] PAL3_RST = 8'hFF;
  typedef enum logic [3:0] {
    EMPTY  = 4'd0,
    DOT    = 4'd1,
    WALL   = 4'd2,
    FILL   = 4'd3,
    HBAR   = 4'd4,
    VBAR   = 4'd5,
    CROSS  = 4'd6,
    BORDER = 4'd7
  } tile_e;
  // Pixel fx occupies row[2*fx+1:2*fx]; unlisted tiles render as empty.
  function automatic logic [15:0] pattern_row(input logic [3:0] tile, input logic [2:0] fy);
    logic mid;
    mid = (fy == 3'd3) || (fy == 3'd4);
    pattern_row = tile == DOT    ? (mid ? 16'h03C0 : 16'h0000) :
                  tile == WALL   ? 16'h5555 :
                  tile == FILL   ? 16'hAAAA :
                  tile == HBAR   ? (mid ? 16'hAAAA : 16'h0000) :
                  tile == VBAR   ? 16'h0280 :
                  tile == CROSS  ? (mid ? 16'hAAAA : 16'h0280) :
                  tile == BORDER ? ((fy == 3'd0 || fy == 3'd7) ? 16'hFFFF : 16'hC003) :
                  16'h0000;
  endfunction
endpackage

// File: rtl/tile_map_ram.sv
// tile_map_ram: simple dual-port tile map, read-first, synchronous read gated by re_i.
module tile_map_ram #(
  parameter int DEPTH = 4800,
  parameter int AW = 13,
  parameter int DW = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i)
    if (we_i && 32'(waddr_i) < DEPTH) mem_q[waddr_i] <= wdata_i;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) rdata_o <= '0;
    else if (re_i) rdata_o <= 32'(raddr_i) < DEPTH ? mem_q[raddr_i] : '0;
endmodule

// File: rtl/maze_tile_renderer.sv
// maze_tile_renderer: 4-stage tile/pattern/palette pixel source with sync realigned to the colour path.
module maze_tile_renderer #(
  parameter int MAP_COLS = 80,
  parameter int MAP_ROWS = 60,
  parameter int TILE_IDX_W = 4,
  parameter int COL_W = 8
) (
  input  logic                  clk100_i,
  input  logic                  rstn_i,
  input  logic                  pix_en_i,
  input  logic [9:0]            pix_x_i,
  input  logic [9:0]            pix_y_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  input  logic                  de_i,
  input  logic                  map_we_i,
  input  logic [12:0]           map_waddr_i,
  input  logic [TILE_IDX_W-1:0] map_wdata_i,
  input  logic                  pal_we_i,
  input  logic [1:0]            pal_idx_i,
  input  logic [COL_W-1:0]      pal_data_i,
  output logic                  vga_hs_o,
  output logic                  vga_vs_o,
  output logic [COL_W-1:0]      vga_col_o,
  output logic                  frame_start_o
);
  import maze_pkg::*;
  logic [12:0] addr_d, addr1_q;
  logic [2:0] fx1_q, fy1_q, fx2_q, fy2_q;
  logic [2:0] de_q, hs_q, vs_q;
  logic [TILE_IDX_W-1:0] tile2;
  logic [15:0] row3;
  logic [1:0] idx3_q;
  logic [COL_W-1:0] pal_q [4];
  assign addr_d = 13'(pix_y_i[9:3]) * 13'(MAP_COLS) + 13'(pix_x_i[9:3]);
  assign row3 = pattern_row(4'(tile2), fy2_q);
  tile_map_ram #(.DEPTH(MAP_COLS * MAP_ROWS), .AW(13), .DW(TILE_IDX_W)) u_map (
    .clk_i(clk100_i), .rstn_i(rstn_i),
    .we_i(map_we_i), .waddr_i(map_waddr_i), .wdata_i(map_wdata_i),
    .re_i(pix_en_i), .raddr_i(addr1_q), .rdata_o(tile2)
  );
  // Bit 0/1/2 of de_q/hs_q/vs_q belong to stages S1/S2/S3.
  always_ff @(posedge clk100_i or negedge rstn_i)
    if (!rstn_i) begin
      addr1_q <= '0;
      fx1_q <= '0;
      fy1_q <= '0;
      fx2_q <= '0;
      fy2_q <= '0;
      idx3_q <= '0;
      de_q <= '0;
      hs_q <= '0;
      vs_q <= '0;
      vga_col_o <= '0;
      vga_hs_o <= 1'b0;
      vga_vs_o <= 1'b0;
    end else if (pix_en_i) begin
      addr1_q <= addr_d;
      fx1_q <= pix_x_i[2:0];
      fy1_q <= pix_y_i[2:0];
      fx2_q <= fx1_q;
      fy2_q <= fy1_q;
      idx3_q <= row3[{fx2_q, 1'b0} +: 2];
      de_q <= {de_q[1:0], de_i};
      hs_q <= {hs_q[1:0], hs_i};
      vs_q <= {vs_q[1:0], vs_i};
      vga_col_o <= de_q[2] ? pal_q[idx3_q] : '0;
      vga_hs_o <= hs_q[2];
      vga_vs_o <= vs_q[2];
    end
  always_ff @(posedge clk100_i or negedge rstn_i)
    if (!rstn_i) begin
      pal_q[0] <= COL_W'(PAL0_RST);
      pal_q[1] <= COL_W'(PAL1_RST);
      pal_q[2] <= COL_W'(PAL2_RST);
      pal_q[3] <= COL_W'(PAL3_RST);
    end else if (pal_we_i) pal_q[pal_idx_i] <= pal_data_i;
  // Fires on the same edge that raises vga_vs_o, so it lasts one clk100.
  always_ff @(posedge clk100_i or negedge rstn_i)
    if (!rstn_i) frame_start_o <= 1'b0;
    else frame_start_o <= pix_en_i & vs_q[2] & ~vga_vs_o;
endmodule

// File: tb/tb_maze_tile_renderer.sv
// tb_maze_tile_renderer: directed scoreboard bench for maze_tile_renderer.
module tb_maze_tile_renderer;
  typedef struct {
    logic       de;
    logic [1:0] idx;
    logic       hs;
    logic       vs;
  } exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic pix_en = 1'b0;
  logic [9:0] pix_x = '0, pix_y = '0;
  logic hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic map_we = 1'b0;
  logic [12:0] map_waddr = '0;
  logic [3:0] map_wdata = '0;
  logic pal_we = 1'b0;
  logic [1:0] pal_idx = '0;
  logic [7:0] pal_data = '0;
  logic vga_hs, vga_vs, fs;
  logic [7:0] vga_col;
  exp_t q[$];
  exp_t last;
  logic [7:0] last_col;
  int map_m[4800];
  logic [7:0] pal_m[4];
  int total = 0, fails = 0;

  always #5 clk = ~clk;

  maze_tile_renderer dut (
    .clk100_i(clk), .rstn_i(rstn), .pix_en_i(pix_en),
    .pix_x_i(pix_x), .pix_y_i(pix_y), .hs_i(hs), .vs_i(vs), .de_i(de),
    .map_we_i(map_we), .map_waddr_i(map_waddr), .map_wdata_i(map_wdata),
    .pal_we_i(pal_we), .pal_idx_i(pal_idx), .pal_data_i(pal_data),
    .vga_hs_o(vga_hs), .vga_vs_o(vga_vs), .vga_col_o(vga_col), .frame_start_o(fs)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] pat(input int t, input int fx, input int fy);
    return t == 1 ? (((fx == 3 || fx == 4) && (fy == 3 || fy == 4)) ? 2'd3 : 2'd0) :
           t == 2 ? 2'd1 : t == 3 ? 2'd2 : 2'd0;
  endfunction

  task automatic prime();
    exp_t z;
    z = '{de: 1'b0, idx: 2'd0, hs: 1'b0, vs: 1'b0};
    q.delete();
    repeat (3) q.push_back(z);
    last = z;
    last_col = 8'h00;
    pal_m = '{8'h00, 8'h03, 8'hFC, 8'hFF};
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("rst_col", vga_col, 8'h00);
      chk("rst_hs", {7'd0, vga_hs}, 8'h00);
      chk("rst_vs", {7'd0, vga_vs}, 8'h00);
      chk("rst_fs", {7'd0, fs}, 8'h00);
      pix_en = (i % 4 == 0);
      @(posedge clk);
      #1;
    end
    pix_en = 1'b0;
    rstn = 1'b1;
    prime();
  endtask

  task automatic tick(input int x, input int y, input logic d, input logic h = 1'b0, input logic v = 1'b0);
    exp_t e;
    logic [7:0] col;
    pix_x = 10'(x);
    pix_y = 10'(y);
    de = d;
    hs = h;
    vs = v;
    pix_en = 1'b1;
    e.de = d;
    e.hs = h;
    e.vs = v;
    e.idx = d ? pat(map_m[(y / 8) * 80 + x / 8], x % 8, y % 8) : 2'd0;
    q.push_back(e);
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    map_we = 1'b0;
    e = q.pop_front();
    col = e.de ? pal_m[e.idx] : 8'h00;
    chk("col", vga_col, col);
    chk("hs", {7'd0, vga_hs}, {7'd0, e.hs});
    chk("vs", {7'd0, vga_vs}, {7'd0, e.vs});
    chk("fs_rise", {7'd0, fs}, {7'd0, e.vs & ~last.vs});
    last = e;
    last_col = col;
    if (pal_we) begin
      pal_m[pal_idx] = pal_data;
      pal_we = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("fs_width", {7'd0, fs}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic map_write(input int a, input int d);
    map_we = 1'b1;
    map_waddr = 13'(a);
    map_wdata = 4'(d);
    @(posedge clk);
    #1;
    map_we = 1'b0;
    if (a < 4800) map_m[a] = d;
  endtask

  task automatic pal_write(input int i, input logic [7:0] d);
    pal_we = 1'b1;
    pal_idx = 2'(i);
    pal_data = d;
    @(posedge clk);
    #1;
    pal_we = 1'b0;
    pal_m[i] = d;
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("hold_col", vga_col, last_col);
      chk("hold_hs", {7'd0, vga_hs}, {7'd0, last.hs});
    end
  endtask

  task automatic blanks(input int n);
    for (int i = 0; i < n; i++) tick(700, 500, 1'b0);
  endtask

  initial begin
    #2;
    apply_reset();
    map_write(0, 2);
    map_write(81, 1);
    map_write(10, 0);
    map_write(11, 2);
    map_write(12, 3);
    map_write(13, 1);
    for (int x = 0; x < 8; x++) tick(x, 0, 1'b1);
    for (int x = 8; x < 16; x++) tick(x, 11, 1'b1);
    for (int x = 80; x < 112; x++) tick(x, 3, 1'b1);
    for (int x = 0; x < 8; x++) tick(x, 0, 1'b0);
    for (int x = 640; x < 800; x++) tick(x, 0, 1'b0, (x >= 656 && x < 752));
    for (int y = 490; y < 494; y++) tick(0, y, 1'b0, 1'b0, (y >= 490 && y < 492));
    blanks(3);
    tick(3, 3, 1'b1);
    map_we = 1'b1;
    map_waddr = 13'd0;
    map_wdata = 4'd1;
    tick(700, 500, 1'b0);
    map_m[0] = 1;
    blanks(3);
    tick(3, 3, 1'b1);
    map_write(5000, 3);
    tick(3, 3, 1'b1);
    tick(0, 0, 1'b1);
    blanks(3);
    for (int x = 8; x < 12; x++) tick(x, 11, 1'b1);
    stall(10);
    for (int x = 12; x < 16; x++) tick(x, 11, 1'b1);
    blanks(3);
    map_write(0, 2);
    pal_write(1, 8'h1C);
    for (int x = 0; x < 4; x++) tick(x, 0, 1'b1);
    pal_we = 1'b1;
    pal_idx = 2'd1;
    pal_data = 8'hE0;
    for (int x = 4; x < 8; x++) tick(x, 0, 1'b1);
    for (int x = 0; x < 3; x++) tick(x, 0, 1'b1);
    apply_reset();
    for (int x = 0; x < 8; x++) tick(x, 0, 1'b1);
    blanks(3);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
